tdc_readout: RTL and testbench
==============================

# tdc_readout

Parametrised digital readout controller for the vernier TDC. Each measurement clears the delay line, fires the start edge and waits a fixed settle time. It then samples the TAPS-wide thermometer code from the line and decodes it to binary. It accumulates 2^AVG_LOG2 such samples and presents the sum on a valid/ready interface to the downstream digital logic (output mux or register file). It generalises the fixed 8-term single-shot readout to any tap count, with on-chip averaging and out-of-range detection.

## Interface
- TAPS, 8: number of delay-line terms sampled; must be ≥ 2.
- AVG_LOG2, 2: log2 of samples accumulated per result; 0 gives single-shot.
- SETTLE, 3: cycles waited after launch before sampling; must be ≥ 2, because it covers the synchroniser.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- meas_req  in  1  request one averaged measurement; accepted only in IDLE.
- busy  out  1  high in every state except IDLE.
- line_clr  out  1  one-cycle pulse that resets the delay line and latches.
- launch  out  1  one-cycle pulse that drives the start edge into the differential generator.
- term  in  TAPS  raw thermometer code; asynchronous to clk; term[0] is the first stage.
- result  out  CODE_W+AVG_LOG2  sum of decoded samples; CODE_W = clog2(TAPS+1).
- sat  out  1  sticky per measurement; set if any sample decoded to TAPS (stop never caught start).
- result_valid  out  1  result and sat are valid.
- result_ready  in  1  consumer accepts the result.

## Operation
- term passes continuously through a 2-flop synchroniser. The decoder reads only the second stage.
- Decode: code = count of leading ones from term[0] upward (first-zero index). All ones gives TAPS; all zeros gives 0.
- FSM states are IDLE, CLEAR, FIRE, WAIT, SAMPLE and DONE.
- IDLE:
  - meas_req=1 moves the FSM to CLEAR.
  - On entry, acc, sample count and sat are cleared.
- CLEAR: line_clr=1 for one cycle, then FIRE.
- FIRE: launch=1 for one cycle, then WAIT.
- WAIT: lasts exactly SETTLE cycles, then SAMPLE.
- SAMPLE:
  - acc += code.
  - sat |= (code==TAPS).
  - The sample count increments.
  - If the count reaches 2^AVG_LOG2, go to DONE; otherwise go to CLEAR.
- DONE:
  - result_valid=1, with result=acc and sat held stable.
  - result_valid && result_ready moves the FSM to IDLE.
- result and sat remain readable after the handshake until the next accepted meas_req clears them.
- Width rule: acc is CODE_W+AVG_LOG2 bits wide, so the maximum TAPS·2^AVG_LOG2 never overflows. No saturation arithmetic is needed.
- meas_req outside IDLE is ignored. That includes the DONE handshake cycle, so a new request is accepted on the following cycle at the earliest.

## Timing
- Reset (asynchronous, immediate):
  - State returns to IDLE.
  - busy, line_clr, launch, result_valid and sat all go to 0.
  - result and the synchroniser flops clear to 0.
- Reset mid-measurement abandons the measurement. There is no partial result, and the next request restarts from CLEAR.
- Per-sample cost is SETTLE+3 cycles.
- meas_req high at edge k puts the FSM in CLEAR (line_clr=1) in cycle k+1. launch is high in cycle k+2.
- result_valid rises 2^AVG_LOG2·(SETTLE+3) cycles after CLEAR is first entered.
- All outputs are registered. line_clr and launch never overlap.

## Configuration
- TDC_BUBBLE_FILTER_EN:
  - Defined: each tap is replaced before decoding by majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[TAPS]=0. This removes single-tap bubbles.
  - Undefined: the synchronised term is decoded directly.
- Port list and timing are identical in both cases.

## Structure
- tdc_pkg contains:
  - the FSM state enum;
  - a constant function for clog2;
  - the CODE_W and RES_W derivation.
- Sub-module therm_decode is combinational. It is parametrised by TAPS and contains the optional bubble filter and the leading-ones decoder.
- The synchroniser, FSM, counter and accumulator live in tdc_readout.

## Test plan
All scenarios use TAPS=8, AVG_LOG2=2, SETTLE=3.
- Reset: assert rst mid-cycle. All outputs read 0 immediately and busy=0.
- Nominal: term=8'b0000_0111 held. A single meas_req pulse produces 4 line_clr and 4 launch pulses 6 cycles apart. result_valid rises 24 cycles after CLEAR entry with result=12 and sat=0.
- Out of range: term=8'hFF. Expect result=32 and sat=1.
- Bubble: term=8'b0000_1011. Without TDC_BUBBLE_FILTER_EN, result=8; with it, result=12.
- Backpressure: hold result_ready=0 for 10 cycles while pulsing meas_req. result_valid, result and busy stay stable, and no new launch occurs. Raising ready causes IDLE on the next cycle.
- Reset mid-operation: assert rst during WAIT of sample 2, then issue a new meas_req with term=8'b0000_0001. Expect a full 4-sample sequence and result=4.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the vernier TDC readout.
package tdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FIRE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int code_w(input int taps);
        return clog2(taps + 1);
    endfunction

    function automatic int res_w(input int taps, input int avg_log2);
        return code_w(taps) + avg_log2;
    endfunction

endpackage

// File: rtl/therm_decode.sv
// Thermometer-to-binary decoder (leading ones from term[0]).
// Optional majority bubble filter when TDC_BUBBLE_FILTER_EN is defined.
module therm_decode
    import tdc_pkg::*;
#(
    parameter int TAPS = 8
) (
    input  logic [TAPS-1:0]         term,
    output logic [code_w(TAPS)-1:0] code
);

    localparam int CODE_W = code_w(TAPS);

    logic [TAPS-1:0] filt;
    logic            hit;

`ifdef TDC_BUBBLE_FILTER_EN
    // Pad with a one below the first stage and a zero above the last.
    logic [TAPS+1:0] ext;
    assign ext = {1'b0, term, 1'b1};

    always_comb begin
        filt = '0;
        for (int i = 0; i < TAPS; i++) begin
            filt[i] = (ext[i] & ext[i+1]) |
                      (ext[i] & ext[i+2]) |
                      (ext[i+1] & ext[i+2]);
        end
    end
`else
    assign filt = term;
`endif

    always_comb begin
        code = CODE_W'(TAPS);
        hit  = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (!hit && !filt[i]) begin
                code = CODE_W'(i);
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_readout.sv
// Vernier TDC readout: clear/fire/settle/sample loop with averaging.
// Build option: TDC_BUBBLE_FILTER_EN enables the tap majority filter.
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int TAPS     = 8,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               meas_req,
    output logic                               busy,
    output logic                               line_clr,
    output logic                               launch,
    input  logic [TAPS-1:0]                    term,
    output logic [res_w(TAPS, AVG_LOG2)-1:0]   result,
    output logic                               sat,
    output logic                               result_valid,
    input  logic                               result_ready
);

    localparam int CODE_W = code_w(TAPS);
    localparam int RES_W  = res_w(TAPS, AVG_LOG2);
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int NSAMP  = 1 << AVG_LOG2;
    localparam int WAIT_W = clog2(SETTLE);

    state_t state;
    state_t state_n;

    logic [TAPS-1:0]   sync1;
    logic [TAPS-1:0]   sync2;
    logic [CODE_W-1:0] code;
    logic [CNT_W-1:0]  cnt;
    logic [WAIT_W-1:0] wcnt;
    logic              last;
    logic              settled;

    // term is asynchronous to clk; only the second stage is decoded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= term;
            sync2 <= sync1;
        end
    end

    therm_decode #(
        .TAPS (TAPS)
    ) u_decode (
        .term (sync2),
        .code (code)
    );

    assign last    = (cnt == CNT_W'(NSAMP - 1));
    assign settled = (wcnt == WAIT_W'(SETTLE - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (meas_req) state_n = S_CLEAR;
            S_CLEAR:  state_n = S_FIRE;
            S_FIRE:   state_n = S_WAIT;
            S_WAIT:   if (settled) state_n = S_SAMPLE;
            S_SAMPLE: state_n = last ? S_DONE : S_CLEAR;
            S_DONE:   if (result_ready) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            line_clr     <= 1'b0;
            launch       <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            busy         <= (state_n != S_IDLE);
            line_clr     <= (state_n == S_CLEAR);
            launch       <= (state_n == S_FIRE);
            result_valid <= (state_n == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (state == S_FIRE) begin
            wcnt <= '0;
        end else if (state == S_WAIT) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    // Result stays readable after the handshake until the next request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            sat    <= 1'b0;
            cnt    <= '0;
        end else if (state == S_IDLE && meas_req) begin
            result <= '0;
            sat    <= 1'b0;
            cnt    <= '0;
        end else if (state == S_SAMPLE) begin
            result <= result + RES_W'(code);
            sat    <= sat | (code == CODE_W'(TAPS));
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tdc_readout.sv
// Randomised self-checking bench for tdc_readout (TAPS=8, AVG_LOG2=2, SETTLE=3).
`timescale 1ns/1ps
module tb_tdc_readout;

    localparam int TAPS     = 8;
    localparam int AVG_LOG2 = 2;
    localparam int SETTLE   = 3;
    localparam int NS       = 1 << AVG_LOG2;
    localparam int PER      = SETTLE + 3;
    localparam int RES_W    = $clog2(TAPS + 1) + AVG_LOG2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             meas_req = 1'b0;
    logic             busy;
    logic             line_clr;
    logic             launch;
    logic [TAPS-1:0]  term = '0;
    logic [RES_W-1:0] result;
    logic             sat;
    logic             result_valid;
    logic             result_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    int nclr, nlau, first_clr, last_clr, first_lau, vpos;
    bit overlap;

    tdc_readout #(
        .TAPS     (TAPS),
        .AVG_LOG2 (AVG_LOG2),
        .SETTLE   (SETTLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .meas_req     (meas_req),
        .busy         (busy),
        .line_clr     (line_clr),
        .launch       (launch),
        .term         (term),
        .result       (result),
        .sat          (sat),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Reference: first-zero index of the (optionally majority-filtered) code.
    function automatic int ref_code(input logic [TAPS-1:0] raw);
        logic [TAPS-1:0] t;
        int n;
        t = raw;
`ifdef TDC_BUBBLE_FILTER_EN
        for (int i = 0; i < TAPS; i++) begin
            int lo, hi;
            lo = 1;
            hi = 0;
            if (i > 0) lo = int'(raw[i-1]);
            if (i < TAPS - 1) hi = int'(raw[i+1]);
            t[i] = (lo + int'(raw[i]) + hi) >= 2;
        end
`endif
        n = 0;
        while (n < TAPS && t[n]) n++;
        return n;
    endfunction

    function automatic logic [RES_W-1:0] ref_result(input logic [TAPS-1:0] raw);
        return RES_W'(ref_code(raw) * NS);
    endfunction

    function automatic logic ref_sat(input logic [TAPS-1:0] raw);
        return ref_code(raw) == TAPS;
    endfunction

    // Issues one request and observes until result_valid (bounded).
    task automatic run_meas(input logic [TAPS-1:0] t);
        int n;
        @(negedge clk);
        term = t;
        @(negedge clk);
        meas_req = 1'b1;
        @(posedge clk);
        #1;
        meas_req = 1'b0;
        nclr = 0; nlau = 0; first_clr = -1; last_clr = -1;
        first_lau = -1; vpos = -1; overlap = 0;
        n = 1;
        while (n <= 200) begin
            if (line_clr) begin
                nclr++;
                if (first_clr < 0) first_clr = n;
                last_clr = n;
            end
            if (launch) begin
                nlau++;
                if (first_lau < 0) first_lau = n;
            end
            if (line_clr && launch) overlap = 1;
            if (result_valid) begin
                vpos = n;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (vpos < 0) begin
            miscompares++;
            $display("FAIL timeout: result_valid not seen in 200 cycles, term=%b", t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        vectors++;
        if ({busy, line_clr, launch, result_valid, sat} !== 5'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b clr=%b lau=%b valid=%b sat=%b result=%0d, want all 0",
                     busy, line_clr, launch, result_valid, sat, result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b want 0", busy);
        end
    endtask

    task automatic test_nominal();
        logic [TAPS-1:0] t;
        t = 8'b0000_0111;
        run_meas(t);
        vectors++;
        if (nclr != NS || nlau != NS) begin
            miscompares++;
            $display("FAIL pulse_count: clr=%0d launch=%0d want %0d each", nclr, nlau, NS);
        end
        vectors++;
        if (first_clr != 1 || last_clr != 1 + PER * (NS - 1) || first_lau != 2) begin
            miscompares++;
            $display("FAIL pulse_timing: first_clr=%0d last_clr=%0d first_lau=%0d want 1/%0d/2",
                     first_clr, last_clr, first_lau, 1 + PER * (NS - 1));
        end
        vectors++;
        if (overlap) begin
            miscompares++;
            $display("FAIL overlap: line_clr and launch high together, want never");
        end
        vectors++;
        if (vpos - first_clr != NS * PER) begin
            miscompares++;
            $display("FAIL latency: got %0d want %0d", vpos - first_clr, NS * PER);
        end
        vectors++;
        if (result !== ref_result(t) || sat !== ref_sat(t)) begin
            miscompares++;
            $display("FAIL nominal_result: result=%0d sat=%b want %0d/%b",
                     result, sat, ref_result(t), ref_sat(t));
        end
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== ref_result(t)) begin
            miscompares++;
            $display("FAIL post_handshake: busy=%b valid=%b result=%0d want 0/0/%0d",
                     busy, result_valid, result, ref_result(t));
        end
    endtask

    task automatic test_sat();
        logic [TAPS-1:0] t;
        t = 8'hFF;
        run_meas(t);
        vectors++;
        if (result !== RES_W'(32) || sat !== 1'b1) begin
            miscompares++;
            $display("FAIL out_of_range: result=%0d sat=%b want 32/1", result, sat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bubble();
        logic [TAPS-1:0] t;
        t = 8'b0000_1011;
        run_meas(t);
        vectors++;
        if (result !== ref_result(t) || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble: result=%0d sat=%b want %0d/0", result, sat, ref_result(t));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [TAPS-1:0] t;
        t = TAPS'((1 << $urandom_range(0, TAPS - 1)) - 1);
        result_ready = 1'b0;
        run_meas(t);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            meas_req = ~meas_req;
            @(posedge clk);
            #1;
            vectors++;
            if (result_valid !== 1'b1 || busy !== 1'b1 || launch !== 1'b0 ||
                line_clr !== 1'b0 || result !== ref_result(t)) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: valid=%b busy=%b lau=%b clr=%b result=%0d want 1/1/0/0/%0d",
                         i, result_valid, busy, launch, line_clr, result, ref_result(t));
            end
        end
        @(negedge clk);
        result_ready = 1'b1;
        meas_req = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || line_clr !== 1'b0 ||
            result !== ref_result(t)) begin
            miscompares++;
            $display("FAIL release: busy=%b valid=%b clr=%b result=%0d want 0/0/0/%0d",
                     busy, result_valid, line_clr, result, ref_result(t));
        end
        @(negedge clk);
        meas_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [TAPS-1:0] t;
        @(negedge clk);
        term = TAPS'($urandom);
        @(negedge clk);
        meas_req = 1'b1;
        @(posedge clk);
        #1;
        meas_req = 1'b0;
        // cycle 1 is CLEAR of sample 1; cycle 10 is mid-WAIT of sample 2
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, line_clr, launch, result_valid, sat} !== 5'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b clr=%b lau=%b valid=%b sat=%b result=%0d, want all 0",
                     busy, line_clr, launch, result_valid, sat, result);
        end
        @(negedge clk);
        rst = 1'b0;
        t = 8'b0000_0001;
        run_meas(t);
        vectors++;
        if (nclr != NS || nlau != NS || first_clr != 1 || vpos - first_clr != NS * PER) begin
            miscompares++;
            $display("FAIL restart_seq: clr=%0d lau=%0d first_clr=%0d lat=%0d want %0d/%0d/1/%0d",
                     nclr, nlau, first_clr, vpos - first_clr, NS, NS, NS * PER);
        end
        vectors++;
        if (result !== RES_W'(4) || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_result: result=%0d sat=%b want 4/0", result, sat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [TAPS-1:0] t;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 0)
                t = TAPS'((1 << $urandom_range(0, TAPS)) - 1);
            else
                t = TAPS'($urandom);
            run_meas(t);
            vectors++;
            if (result !== ref_result(t) || sat !== ref_sat(t) ||
                vpos - first_clr != NS * PER) begin
                miscompares++;
                $display("FAIL random[%0d] term=%b: result=%0d sat=%b lat=%0d want %0d/%b/%0d",
                         k, t, result, sat, vpos - first_clr,
                         ref_result(t), ref_sat(t), NS * PER);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sat();
        test_bubble();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
